crc_framer: RTL and testbench

Parametrised CRC framing stage for the transmit path. It sits between the PHR/PSDU FIFO and the modulator and replaces the fixed serial CRC block. Incoming data beats pass through with one cycle of latency. At end of frame it appends the CRC register MSB-first as CRC_W/DATA_W extra beats. Width, polynomial and initial value are parameters, so the same block serves the bit-serial (DATA_W=1) and byte-wide (DATA_W=8) paths.

---
 rtl/crc_pkg.sv | 13 +
 rtl/crc_framer_if.sv | 34 +++
 rtl/crc_step.sv | 20 ++
 rtl/crc_framer.sv | 105 ++++++++++
 tb/tb_crc_framer.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared framer state encoding and CRC-16/CCITT constants
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    APPEND
  } crc_state_t;

  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT_ZERO  = 16'h0000;

endpackage

// File: rtl/crc_framer_if.sv
// rtl/crc_framer_if.sv - framer stream handshake bundle (CRC_FRAMER_CHECK_EN adds check outputs)
interface crc_framer_if #(
  parameter int DATA_W = 1
) ();

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_crc;
  logic              busy;
`ifdef CRC_FRAMER_CHECK_EN
  logic              crc_ok;
  logic              crc_ok_valid;
`endif

  modport master (
    output in_data, in_valid,
    input  in_ready, out_data, out_valid, out_crc, busy
`ifdef CRC_FRAMER_CHECK_EN
    , input crc_ok, crc_ok_valid
`endif
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, out_data, out_valid, out_crc, busy
`ifdef CRC_FRAMER_CHECK_EN
    , output crc_ok, crc_ok_valid
`endif
  );

endinterface

// File: rtl/crc_step.sv
// rtl/crc_step.sv - combinational MSB-first CRC update over one DATA_W-bit beat
module crc_step #(
  parameter int               DATA_W = 1,
  parameter int               CRC_W  = 16,
  parameter logic [CRC_W-1:0] POLY   = 16'h1021
) (
  input  logic [CRC_W-1:0]  crc_in,
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  crc_out
);

  // Unrolled serial LFSR: the beat's MSB is the earliest bit in time.
  always_comb begin
    crc_out = crc_in;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      crc_out = {crc_out[CRC_W-2:0], 1'b0} ^ ((crc_out[CRC_W-1] ^ data[i]) ? POLY : '0);
    end
  end

endmodule

// File: rtl/crc_framer.sv
// rtl/crc_framer.sv - pass-through CRC framer, appends CRC beats (CRC_FRAMER_CHECK_EN: residue check, no append)
module crc_framer
  import crc_pkg::*;
#(
  parameter int               DATA_W = 1,
  parameter int               CRC_W  = 16,
  parameter logic [CRC_W-1:0] POLY   = CRC16_CCITT_POLY,
  parameter logic [CRC_W-1:0] INIT   = CRC16_INIT_ZERO
) (
  input  logic         clk,
  input  logic         reset,
  crc_framer_if.slave  bus
);

  localparam int BEATS = CRC_W / DATA_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  crc_state_t       state;
  logic [CRC_W-1:0] crc;
  logic [CRC_W-1:0] step_in;
  logic [CRC_W-1:0] crc_next;
  logic [CNT_W-1:0] cnt;

  assign step_in = (state == IDLE) ? INIT : crc;

  crc_step #(
    .DATA_W (DATA_W),
    .CRC_W  (CRC_W),
    .POLY   (POLY)
  ) u_step (
    .crc_in  (step_in),
    .data    (bus.in_data),
    .crc_out (crc_next)
  );

  assign bus.in_ready = (state != APPEND);

  // busy is registered alongside out_* so it stays high while the last CRC beat is on the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      crc           <= INIT;
      cnt           <= '0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_crc   <= 1'b0;
      bus.busy      <= 1'b0;
`ifdef CRC_FRAMER_CHECK_EN
      bus.crc_ok       <= 1'b0;
      bus.crc_ok_valid <= 1'b0;
`endif
    end else begin
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_crc   <= 1'b0;
`ifdef CRC_FRAMER_CHECK_EN
      bus.crc_ok_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          bus.busy <= bus.in_valid;
          if (bus.in_valid) begin
            crc           <= crc_next;
            bus.out_data  <= bus.in_data;
            bus.out_valid <= 1'b1;
            state         <= DATA;
          end
        end
        DATA: begin
          if (bus.in_valid) begin
            crc           <= crc_next;
            bus.out_data  <= bus.in_data;
            bus.out_valid <= 1'b1;
          end else begin
`ifdef CRC_FRAMER_CHECK_EN
            bus.crc_ok       <= (crc == '0);
            bus.crc_ok_valid <= 1'b1;
            bus.busy         <= 1'b0;
            crc              <= INIT;
            state            <= IDLE;
`else
            cnt   <= LAST_BEAT;
            state <= APPEND;
`endif
          end
        end
        APPEND: begin
          bus.out_data  <= crc[CRC_W-1 -: DATA_W];
          bus.out_valid <= 1'b1;
          bus.out_crc   <= 1'b1;
          if (cnt == '0) begin
            crc   <= INIT;
            state <= IDLE;
          end else begin
            crc <= crc << DATA_W;
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_framer.sv
// tb/tb_crc_framer.sv - self-checking bench for crc_framer (byte and bit-serial instances, CRC_FRAMER_CHECK_EN aware)
module tb_crc_framer;
  import crc_pkg::*;

  typedef struct {
    logic       crc;
    logic [7:0] d;
    int         cyc;
  } beat_t;

  typedef struct {
    int          len;
    logic [7:0]  b [12];
    logic [15:0] crc;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  beat_t st8[$];
  beat_t st1[$];
  beat_t b8, b1;

  crc_framer_if #(.DATA_W(8)) bus8 ();
  crc_framer_if #(.DATA_W(1)) bus1 ();

  crc_framer #(.DATA_W(8), .CRC_W(16), .POLY(CRC16_CCITT_POLY), .INIT(CRC16_INIT_ZERO)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  crc_framer #(.DATA_W(1), .CRC_W(16), .POLY(CRC16_CCITT_POLY), .INIT(CRC16_INIT_ZERO)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus8.out_valid) begin
      b8.crc = bus8.out_crc; b8.d = bus8.out_data; b8.cyc = cyc;
      st8.push_back(b8);
    end
    if (bus1.out_valid) begin
      b1.crc = bus1.out_crc; b1.d = {7'd0, bus1.out_data}; b1.cyc = cyc;
      st1.push_back(b1);
    end
  end

`ifdef CRC_FRAMER_CHECK_EN
  int   okv_cnt = 0;
  logic last_ok = 1'b0;
  always @(negedge clk) begin
    if (bus8.crc_ok_valid) begin
      okv_cnt++;
      last_ok = bus8.crc_ok;
    end
  end
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s: timed out", name);
  endtask

  // Polynomial long division of the augmented message; INIT enters as I*x^len.
  function automatic logic [15:0] model_crc(input logic [7:0] d[$]);
    bit          m[$];
    logic [16:0] g;
    logic [15:0] r;
    g = {1'b1, CRC16_CCITT_POLY};
    foreach (d[i]) for (int b = 7; b >= 0; b--) m.push_back(d[i][b]);
    repeat (16) m.push_back(1'b0);
    for (int k = 0; k < 16; k++) m[k] ^= CRC16_INIT_ZERO[15-k];
    for (int i = 0; i < m.size() - 16; i++)
      if (m[i]) for (int j = 0; j <= 16; j++) m[i+j] ^= g[16-j];
    for (int k = 0; k < 16; k++) r[15-k] = m[m.size()-16+k];
    return r;
  endfunction

  task automatic send8(input logic [7:0] d[$]);
    int g;
    foreach (d[i]) begin
      bus8.in_data = d[i];
      bus8.in_valid = 1'b1;
      g = 0;
      while (!bus8.in_ready && g < 50) begin @(negedge clk); g++; end
      if (g >= 50) fail("send8_ready");
      @(negedge clk);
    end
    bus8.in_valid = 1'b0;
  endtask

  task automatic send1(input logic [7:0] d[$]);
    foreach (d[i]) for (int b = 7; b >= 0; b--) begin
      bus1.in_data = d[i][b];
      bus1.in_valid = 1'b1;
      @(negedge clk);
    end
    bus1.in_valid = 1'b0;
  endtask

  task automatic wait_idle8();
    int g = 0;
    while (bus8.busy && g < 200) begin @(negedge clk); g++; end
    if (g >= 200) fail("wait_idle8");
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle1();
    int g = 0;
    while (bus1.busy && g < 400) begin @(negedge clk); g++; end
    if (g >= 400) fail("wait_idle1");
    repeat (2) @(negedge clk);
  endtask

  task automatic check_frame8(input string name, input logic [7:0] d[$], input logic [15:0] c);
    int n = d.size();
    int bad = 0;
    check({name, "_len"}, 32'(st8.size() >= n + 2), 32'd1);
    if (st8.size() >= n + 2) begin
      for (int i = 0; i < n; i++) if (st8[i].crc !== 1'b0 || st8[i].d !== d[i]) bad++;
      check({name, "_payload_bad"}, 32'(bad), 32'd0);
      check({name, "_crc_hi"}, {23'd0, st8[n].crc, st8[n].d}, {23'd0, 1'b1, c[15:8]});
      check({name, "_crc_lo"}, {23'd0, st8[n+1].crc, st8[n+1].d}, {23'd0, 1'b1, c[7:0]});
      if (n > 0) check({name, "_gap"}, 32'(st8[n].cyc - st8[n-1].cyc), 32'd2);
      check({name, "_crc_run"}, 32'(st8[n+1].cyc - st8[n].cyc), 32'd1);
      repeat (n + 2) void'(st8.pop_front());
    end else st8.delete();
  endtask

  task automatic check_frame1(input string name, input logic [7:0] d[$], input logic [15:0] c);
    int          n = 8 * d.size();
    int          bad = 0;
    int          badf = 0;
    logic [15:0] r;
    check({name, "_len"}, 32'(st1.size() >= n + 16), 32'd1);
    if (st1.size() >= n + 16) begin
      for (int i = 0; i < n; i++)
        if (st1[i].crc !== 1'b0 || st1[i].d[0] !== d[i/8][7 - i%8]) bad++;
      for (int k = 0; k < 16; k++) begin
        r[15-k] = st1[n+k].d[0];
        if (st1[n+k].crc !== 1'b1 || st1[n+k].cyc != st1[n].cyc + k) badf++;
      end
      check({name, "_payload_bad"}, 32'(bad), 32'd0);
      check({name, "_crc"}, {16'd0, r}, {16'd0, c});
      check({name, "_crc_flags"}, 32'(badf), 32'd0);
      check({name, "_gap"}, 32'(st1[n].cyc - st1[n-1].cyc), 32'd2);
      repeat (n + 16) void'(st1.pop_front());
    end else st1.delete();
  endtask

  initial begin
    vec_t       vecs[3];
    logic [7:0] q[$];
    logic [7:0] q9[$];
    int         len, lowcnt, g;

    vecs[0].len = 9; for (int i = 0; i < 9; i++) vecs[0].b[i] = 8'h31 + 8'(i); vecs[0].crc = 16'h31C3;
    vecs[1].len = 1; vecs[1].b[0] = 8'h01; vecs[1].crc = 16'h1021;
    vecs[2].len = 1; vecs[2].b[0] = 8'h00; vecs[2].crc = 16'h0000;
    for (int i = 0; i < 9; i++) q9.push_back(8'h31 + 8'(i));

    bus8.in_data = '0; bus8.in_valid = 1'b0;
    bus1.in_data = '0; bus1.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, bus8.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus8.out_valid}, 32'd0);
    check("rst_out_crc", {31'd0, bus8.out_crc}, 32'd0);
    check("rst_out_data", {24'd0, bus8.out_data}, 32'd0);
    check("rst_busy", {31'd0, bus8.busy}, 32'd0);
    check("rst1_busy", {30'd0, bus1.busy, bus1.out_valid}, 32'd0);
`ifdef CRC_FRAMER_CHECK_EN
    check("rst_crc_ok", {30'd0, bus8.crc_ok, bus8.crc_ok_valid}, 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);

`ifndef CRC_FRAMER_CHECK_EN
    for (int v = 0; v < 3; v++) begin
      q.delete();
      for (int i = 0; i < vecs[v].len; i++) q.push_back(vecs[v].b[i]);
      send8(q);
      wait_idle8();
      check_frame8($sformatf("vec%0d", v), q, vecs[v].crc);
      check($sformatf("vec%0d_drained", v), 32'(st8.size()), 32'd0);
    end

    send1(q9);
    wait_idle1();
    check_frame1("serial_123456789", q9, 16'h31C3);

    // Upstream keeps in_valid high across end of frame; held beat starts frame 2.
    send8(q9);
    @(negedge clk);
    bus8.in_data = 8'h01; bus8.in_valid = 1'b1;
    lowcnt = 0; g = 0;
    while (!bus8.in_ready && g < 20) begin lowcnt++; @(negedge clk); g++; end
    @(negedge clk);
    bus8.in_valid = 1'b0;
    wait_idle8();
    check("held_ready_low_cycles", 32'(lowcnt), 32'd2);
    check_frame8("held_f1", q9, 16'h31C3);
    q.delete(); q.push_back(8'h01);
    check_frame8("held_f2", q, 16'h1021);
    check("held_drained", 32'(st8.size()), 32'd0);

    // Reset in the third payload cycle.
    bus8.in_data = 8'hAA; bus8.in_valid = 1'b1; @(negedge clk);
    bus8.in_data = 8'hBB; @(negedge clk);
    bus8.in_data = 8'hCC; reset = 1'b1; @(negedge clk);
    check("midrst_outs", {28'd0, bus8.out_valid, bus8.out_crc, bus8.busy, |bus8.out_data}, 32'd0);
    check("midrst_in_ready", {31'd0, bus8.in_ready}, 32'd1);
    reset = 1'b0; bus8.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_beats", 32'(st8.size()), 32'd2);
    g = 0; foreach (st8[i]) if (st8[i].crc) g++;
    check("midrst_no_crc", 32'(g), 32'd0);
    st8.delete();
    send8(q9);
    wait_idle8();
    check_frame8("after_rst", q9, 16'h31C3);

    for (int f = 0; f < 25; f++) begin
      len = int'($urandom_range(1, 12));
      q.delete();
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      send8(q);
      wait_idle8();
      check_frame8($sformatf("rand8_%0d", f), q, model_crc(q));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    for (int f = 0; f < 4; f++) begin
      len = int'($urandom_range(1, 3));
      q.delete();
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      send1(q);
      wait_idle1();
      check_frame1($sformatf("rand1_%0d", f), q, model_crc(q));
    end
`else
    q = q9; q.push_back(8'h31); q.push_back(8'hC3);
    send8(q);
    wait_idle8();
    check("chk_good_pulses", 32'(okv_cnt), 32'd1);
    check("chk_good_ok", {31'd0, last_ok}, 32'd1);
    check("chk_good_no_crc_beats", 32'(st8.size()), 32'd11);
    st8.delete(); okv_cnt = 0;

    q[10] = 8'hC2;
    send8(q);
    wait_idle8();
    check("chk_bad_pulses", 32'(okv_cnt), 32'd1);
    check("chk_bad_ok", {31'd0, last_ok}, 32'd0);
    st8.delete(); okv_cnt = 0;

    bus8.in_data = 8'hAA; bus8.in_valid = 1'b1; @(negedge clk);
    bus8.in_data = 8'hBB; @(negedge clk);
    reset = 1'b1; @(negedge clk);
    reset = 1'b0; bus8.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("chk_midrst_no_pulse", 32'(okv_cnt), 32'd0);
    st8.delete();

    for (int f = 0; f < 15; f++) begin
      logic [15:0] c;
      logic        corrupt;
      len = int'($urandom_range(1, 10));
      q.delete();
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      c = model_crc(q);
      corrupt = 1'($urandom);
      q.push_back(c[15:8]);
      q.push_back(corrupt ? ~c[7:0] : c[7:0]);
      okv_cnt = 0;
      send8(q);
      wait_idle8();
      check($sformatf("chk_rand%0d_pulses", f), 32'(okv_cnt), 32'd1);
      check($sformatf("chk_rand%0d_ok", f), {31'd0, last_ok}, {31'd0, ~corrupt});
      st8.delete();
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
